mic_decimator: RTL and testbench

MIC_DECIMATOR -- requirements
Module: mic_decimator

---
 rtl/mic_decimator.sv | 122 ++++++++++++
 tb/tb_mic_decimator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mic_decimator.sv
// mic_decimator -- block-sum decimator for a signed microphone sample stream.
//
// Accumulates `ratio` accepted samples (ratio==0 is treated as 1) into a
// guard-extended accumulator. At block end it applies a rounded arithmetic
// right shift, saturates the result to DATA_W bits and presents it on a
// registered valid/ready output. An irq pulse marks each new result.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          decimation enable; low discards any partial block
//   ratio           samples per output (latched at block start)
//   shift           rounding right-shift, values above GUARD_W clamp to GUARD_W
//   mic_dir_data    signed input sample
//   mic_dir_rdy     one-cycle strobe qualifying mic_dir_data
//   out_audio       decimated signed sample, registered
//   out_valid       out_audio holds an unconsumed result
//   out_ready       consumer accepts out_audio while out_valid is high
//   irq             one-cycle pulse per new result
//   overrun         sticky flag: an unconsumed result was overwritten
//   clr_ovr         clears overrun (a simultaneous set wins)
module mic_decimator #(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned RATIO_W = 4,
  parameter int unsigned GUARD_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [RATIO_W-1:0] ratio,
  input  logic [2:0]         shift,
  input  logic [DATA_W-1:0]  mic_dir_data,
  input  logic               mic_dir_rdy,
  output logic [DATA_W-1:0]  out_audio,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               irq,
  output logic               overrun,
  input  logic               clr_ovr
);

  localparam int unsigned AW = DATA_W + GUARD_W;

  // Saturation bounds expressed at the rounding width (AW+1 bits).
  localparam logic signed [AW:0] SAT_MAX = {{(GUARD_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {{(GUARD_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_new;
  logic signed [AW-1:0] sample_x;
  logic [RATIO_W-1:0]   count;
  logic [RATIO_W-1:0]   r_eff;
  logic [RATIO_W-1:0]   ratio_in;
  logic [RATIO_W-1:0]   r_cur;
  logic                 accept;
  logic                 last;
  logic                 load;
  int unsigned          sh;
  logic signed [AW:0]   sum_x;
  logic signed [AW:0]   half;
  logic signed [AW:0]   rounded;
  logic [DATA_W-1:0]    result;

  // Block bookkeeping. At count==0 the block length comes straight from the
  // ratio input so a one-sample block completes on the same strobe.
  always_comb begin
    accept   = enable && mic_dir_rdy;
    sample_x = {{GUARD_W{mic_dir_data[DATA_W-1]}}, mic_dir_data};
    ratio_in = (ratio == '0) ? RATIO_W'(1) : ratio;
    r_cur    = (count == '0) ? ratio_in : r_eff;
    last     = (count == r_cur - RATIO_W'(1));
    load     = accept && last;
    acc_new  = (count == '0) ? sample_x : acc + sample_x;
  end

  // Round-half-up arithmetic shift, then saturate. One extra bit of headroom
  // keeps the rounding addend from wrapping a near-full-scale sum.
  always_comb begin
    sh = 32'(shift);
    if (sh > GUARD_W) sh = GUARD_W;
    sum_x = {acc_new[AW-1], acc_new};
    half  = '0;
    if (sh != 0) half = $signed({{AW{1'b0}}, 1'b1}) <<< (sh - 1);
    rounded = (sum_x + half) >>> sh;
    if (rounded > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
    else if (rounded < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
    else                        result = rounded[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      count     <= '0;
      r_eff     <= RATIO_W'(1);
      out_audio <= '0;
      out_valid <= 1'b0;
      irq       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      irq <= load;

      if (!enable) begin
        count <= '0;
        acc   <= '0;
      end else if (accept) begin
        acc <= acc_new;
        if (count == '0) r_eff <= ratio_in;
        count <= last ? '0 : count + RATIO_W'(1);
      end

      if (load) begin
        out_audio <= result;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (load && out_valid && !out_ready) overrun <= 1'b1;
      else if (clr_ovr)                    overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mic_decimator.sv
module tb_mic_decimator;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  ratio;
  logic [2:0]  shift;
  logic [23:0] mic_dir_data;
  logic        mic_dir_rdy;
  logic [23:0] out_audio;
  logic        out_valid;
  logic        out_ready;
  logic        irq;
  logic        overrun;
  logic        clr_ovr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_v;

  mic_decimator #(.DATA_W(24), .RATIO_W(4), .GUARD_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ratio(ratio), .shift(shift),
    .mic_dir_data(mic_dir_data), .mic_dir_rdy(mic_dir_rdy),
    .out_audio(out_audio), .out_valid(out_valid), .out_ready(out_ready),
    .irq(irq), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  // Drives one strobe; returns 1 time unit after the capturing edge.
  task automatic send(input logic [23:0] d);
    mic_dir_data = d;
    mic_dir_rdy  = 1'b1;
    @(posedge clk); #1;
    mic_dir_rdy  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; ratio = 4'd1; shift = 3'd0;
    mic_dir_data = 24'd5; mic_dir_rdy = 1'b1;
    out_ready = 1'b0; clr_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; mic_dir_rdy = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    n_tests++; if (out_audio !== 24'd0) begin n_fail++; $display("FAIL reset_audio got %h want 0", out_audio); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
  endtask

  task automatic test_basic();
    ratio = 4'd3; shift = 3'd2;
    exp_q.push_back(24'd150);
    send(24'd100); send(24'd200);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early got %b want 0", out_valid); end
    send(24'd300);
    exp_v = exp_q.pop_front();
    n_tests++; if (out_audio !== exp_v) begin n_fail++; $display("FAIL basic_audio got %0d want %0d", out_audio, exp_v); end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq got %b want 1", irq); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid); end
    @(posedge clk); #1;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_pulse got %b want 0", irq); end
    n_tests++; if (out_valid !== 1'b1 || out_audio !== exp_v) begin n_fail++; $display("FAIL basic_hold got %b/%0d want 1/%0d", out_valid, out_audio, exp_v); end
    consume();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consume got %b want 0", out_valid); end
  endtask

  task automatic test_rounding();
    ratio = 4'd3; shift = 3'd2;
    exp_q.push_back(24'hFFFFFF);
    repeat (3) send(24'hFFFFFF);
    exp_v = exp_q.pop_front();
    n_tests++; if (out_audio !== exp_v) begin n_fail++; $display("FAIL round_m1 got %h want %h", out_audio, exp_v); end
    consume();
    exp_q.push_back(24'hFFFFFF);
    repeat (3) send(24'hFFFFFE);
    exp_v = exp_q.pop_front();
    n_tests++; if (out_audio !== exp_v) begin n_fail++; $display("FAIL round_m2 got %h want %h", out_audio, exp_v); end
    consume();
  endtask

  task automatic test_saturation();
    ratio = 4'd15; shift = 3'd0;
    exp_q.push_back(24'h7FFFFF);
    repeat (15) send(24'h7FFFFF);
    exp_v = exp_q.pop_front();
    n_tests++; if (out_audio !== exp_v || irq !== 1'b1) begin n_fail++; $display("FAIL sat_pos got %h/%b want %h/1", out_audio, irq, exp_v); end
    consume();
    exp_q.push_back(24'h800000);
    repeat (15) send(24'h800000);
    exp_v = exp_q.pop_front();
    n_tests++; if (out_audio !== exp_v || irq !== 1'b1) begin n_fail++; $display("FAIL sat_neg got %h/%b want %h/1", out_audio, irq, exp_v); end
    consume();
  endtask

  task automatic test_overrun();
    ratio = 4'd2; shift = 3'd0; out_ready = 1'b0;
    exp_q.push_back(24'd3);
    send(24'd1); send(24'd2);
    exp_v = exp_q.pop_front();
    n_tests++; if (out_audio !== exp_v || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first got %0d/%b want %0d/0", out_audio, overrun, exp_v); end
    exp_q.push_back(24'd11);
    send(24'd5); send(24'd6);
    exp_v = exp_q.pop_front();
    n_tests++; if (out_audio !== exp_v || out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_second got %0d/%b want %0d/1", out_audio, out_valid, exp_v); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b want 1", overrun); end
    clr_ovr = 1'b1; @(posedge clk); #1; clr_ovr = 1'b0;
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", overrun); end
    // set and clear on the same edge
    exp_q.push_back(24'd2);
    send(24'd1);
    clr_ovr = 1'b1; send(24'd1); clr_ovr = 1'b0;
    exp_v = exp_q.pop_front();
    n_tests++; if (overrun !== 1'b1 || out_audio !== exp_v) begin n_fail++; $display("FAIL ovr_setwins got %b/%0d want 1/%0d", overrun, out_audio, exp_v); end
    clr_ovr = 1'b1; @(posedge clk); #1; clr_ovr = 1'b0;
    // load coinciding with consumption
    exp_q.push_back(24'd4);
    send(24'd2);
    out_ready = 1'b1; send(24'd2); out_ready = 1'b0;
    exp_v = exp_q.pop_front();
    n_tests++; if (overrun !== 1'b0 || out_valid !== 1'b1 || out_audio !== exp_v) begin n_fail++; $display("FAIL ovr_consume_load got %b/%b/%0d want 0/1/%0d", overrun, out_valid, out_audio, exp_v); end
    consume();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain got %b want 0", out_valid); end
  endtask

  task automatic test_ratio_change();
    ratio = 4'd3; shift = 3'd0;
    exp_q.push_back(24'd6);
    send(24'd1);
    ratio = 4'd2;
    send(24'd2);
    n_tests++; if (irq !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rchg_early got %b/%b want 0/0", irq, out_valid); end
    send(24'd3);
    exp_v = exp_q.pop_front();
    n_tests++; if (out_audio !== exp_v || irq !== 1'b1) begin n_fail++; $display("FAIL rchg_old got %0d/%b want %0d/1", out_audio, irq, exp_v); end
    consume();
    exp_q.push_back(24'd9);
    send(24'd4); send(24'd5);
    exp_v = exp_q.pop_front();
    n_tests++; if (out_audio !== exp_v || irq !== 1'b1) begin n_fail++; $display("FAIL rchg_new got %0d/%b want %0d/1", out_audio, irq, exp_v); end
    consume();
  endtask

  task automatic test_reset_midblock();
    ratio = 4'd3; shift = 3'd0;
    send(24'd7); send(24'd8);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    exp_q.push_back(24'd60);
    send(24'd10); send(24'd20);
    n_tests++; if (out_valid !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_early got %b/%b want 0/0", out_valid, irq); end
    send(24'd30);
    exp_v = exp_q.pop_front();
    n_tests++; if (out_audio !== exp_v || irq !== 1'b1) begin n_fail++; $display("FAIL rstmid_sum got %0d/%b want %0d/1", out_audio, irq, exp_v); end
    consume();
  endtask

  task automatic test_enable_low();
    ratio = 4'd3; shift = 3'd0;
    send(24'd1); send(24'd2);
    enable = 1'b0;
    send(24'd100);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL enable_ignore got %b want 0", irq); end
    enable = 1'b1;
    exp_q.push_back(24'd15);
    send(24'd4); send(24'd5); send(24'd6);
    exp_v = exp_q.pop_front();
    n_tests++; if (out_audio !== exp_v || irq !== 1'b1) begin n_fail++; $display("FAIL enable_discard got %0d/%b want %0d/1", out_audio, irq, exp_v); end
    consume();
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int unsigned n;
      int unsigned e;
      longint sum;
      logic signed [23:0] s;
      ratio = 4'($urandom_range(0, 15));
      shift = 3'($urandom_range(0, 7));
      if (k == 0) ratio = 4'd0;
      if (k == 1) shift = 3'd7;
      n = (ratio == 4'd0) ? 1 : 32'(ratio);
      e = (32'(shift) > 4) ? 4 : 32'(shift);
      sum = 0;
      for (int unsigned i = 0; i < n; i++) begin
        s = 24'($urandom);
        sum += longint'(s);
        if (i == n - 1) begin
          if (e > 0) sum = (sum + (64'sd1 <<< (e - 1))) >>> e;
          if (sum > 64'sd8388607) sum = 64'sd8388607;
          if (sum < -64'sd8388608) sum = -64'sd8388608;
          exp_q.push_back(24'(sum));
        end
        send(s);
      end
      exp_v = exp_q.pop_front();
      n_tests++; if (out_audio !== exp_v || irq !== 1'b1) begin n_fail++; $display("FAIL random_%0d got %h/%b want %h/1 (ratio %0d shift %0d)", k, out_audio, irq, exp_v, ratio, shift); end
      consume();
    end
  endtask

  initial begin
    mic_dir_data = '0;
    mic_dir_rdy  = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_overrun();
    test_ratio_change();
    test_reset_midblock();
    test_enable_low();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
